div_sched: RTL



---
 rtl/div_pkg.sv | 20 ++
 rtl/div_iter_core.sv | 78 +++++++
 rtl/div_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the shared divider scheduler.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 16;

    // Quotient reported for a zero divisor (all ones at the default width).
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Bit offset of requester idx inside a packed operand bus.
    function automatic int unsigned op_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// Restoring shift-subtract divider datapath, one quotient bit per step, MSB first.
module div_iter_core
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_nxt_c_o,
    output logic [WIDTH-1:0] rem_nxt_c_o,
    output logic             done_c_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // One restoring step; the quotient register doubles as the dividend shifter.
    // The stored remainder is always below the divisor, so a clear borrow bit
    // of the WIDTH+1 subtraction means the shifted remainder fits.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dsr_q};
        fits      = ~diff[WIDTH];
        rem_step  = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], fits};

        rem_d = rem_q;
        quo_d = quo_q;
        dsr_d = dsr_q;
        cnt_d = cnt_q;
        if (start_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dsr_d = divisor_i;
            cnt_d = CW'(WIDTH - 1);
        end else if (step_i) begin
            rem_d = rem_step;
            quo_d = quo_step;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dsr_q <= dsr_d;
            cnt_q <= cnt_d;
        end
    end

    assign quo_nxt_c_o = quo_step;
    assign rem_nxt_c_o = rem_step;
    assign done_c_o    = step_i && (cnt_q == '0);

endmodule

// File: rtl/div_sched.sv
// Round-robin arbiter and sequencer sharing one iterative divider among requesters.
module div_sched
    import div_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_quotient,
    output logic [WIDTH-1:0]      rsp_remainder,
    output logic                  rsp_div0,
    output logic                  busy
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_quo_q, rsp_quo_d;
    logic [WIDTH-1:0] rsp_rem_q, rsp_rem_d;
    logic             rsp_div0_q, rsp_div0_d;
    logic             busy_q, busy_d;

    logic [NREQ-1:0]  gnt_c;
    logic [IDW-1:0]   gnt_idx_c;
    logic             gnt_any_c;
    logic             accept_c;
    logic [WIDTH-1:0] sel_dvd_c;
    logic [WIDTH-1:0] sel_dsr_c;

    logic             core_start_c;
    logic             core_step_c;
    logic             core_done_c;
    logic [WIDTH-1:0] core_quo_c;
    logic [WIDTH-1:0] core_rem_c;

    // Round-robin pick: first valid at or above the pointer, then wrap to below it.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any_c && req_valid[i] && (IDW'(i) >= ptr_q)) begin
                gnt_c[i]  = 1'b1;
                gnt_idx_c = IDW'(i);
                gnt_any_c = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any_c && req_valid[i] && (IDW'(i) < ptr_q)) begin
                gnt_c[i]  = 1'b1;
                gnt_idx_c = IDW'(i);
                gnt_any_c = 1'b1;
            end
        end
    end

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_dvd_c = '0;
        sel_dsr_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                sel_dvd_c = req_dividend[op_lsb(i, WIDTH) +: WIDTH];
                sel_dsr_c = req_divisor[op_lsb(i, WIDTH) +: WIDTH];
            end
        end
    end

    assign accept_c  = (state_q == IDLE) && gnt_any_c && !rst;
    assign req_ready = accept_c ? gnt_c : '0;

    div_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .start_i     (core_start_c),
        .step_i      (core_step_c),
        .dividend_i  (sel_dvd_c),
        .divisor_i   (sel_dsr_c),
        .quo_nxt_c_o (core_quo_c),
        .rem_nxt_c_o (core_rem_c),
        .done_c_o    (core_done_c)
    );

    // Sequencer next state and response capture.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_quo_d    = rsp_quo_q;
        rsp_rem_d    = rsp_rem_q;
        rsp_div0_d   = rsp_div0_q;
        core_start_c = 1'b0;
        core_step_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    ptr_d = (gnt_idx_c == IDW'(NREQ - 1)) ? '0 : gnt_idx_c + IDW'(1);
                    id_d  = gnt_idx_c;
                    if (sel_dsr_c == '0) begin
                        // Zero divisor skips the datapath entirely.
                        state_d    = RESP;
                        rsp_id_d   = gnt_idx_c;
                        rsp_quo_d  = {WIDTH{1'b1}};
                        rsp_rem_d  = sel_dvd_c;
                        rsp_div0_d = 1'b1;
                    end else begin
                        state_d      = CALC;
                        core_start_c = 1'b1;
                    end
                end
            end
            CALC: begin
                core_step_c = 1'b1;
                if (core_done_c) begin
                    state_d    = RESP;
                    rsp_id_d   = id_q;
                    rsp_quo_d  = core_quo_c;
                    rsp_rem_d  = core_rem_c;
                    rsp_div0_d = 1'b0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // State and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_quo_q   <= '0;
            rsp_rem_q   <= '0;
            rsp_div0_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_quo_q   <= rsp_quo_d;
            rsp_rem_q   <= rsp_rem_d;
            rsp_div0_q  <= rsp_div0_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_quotient  = rsp_quo_q;
    assign rsp_remainder = rsp_rem_q;
    assign rsp_div0      = rsp_div0_q;
    assign busy          = busy_q;

endmodule
